// File: rtl/alu_pkg.sv
// Shared types and constants for the kernel ALU: operation classes, per-class
// function codes, CPSR flag bit positions and kernel cache geometry.
package alu_pkg;

    localparam int KROWS  = 3;
    localparam int KWIDTH = 24;

    typedef enum logic [1:0] {
        ARITH  = 2'b00,
        LOGIC  = 2'b01,
        KERNEL = 2'b10,
        SHIFT  = 2'b11
    } funtype_e;

    // ARITH class
    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_MOV = 2'b11;

    // LOGIC class
    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_ORR = 2'b01;
    localparam logic [1:0] LOGIC_EOR = 2'b10;
    localparam logic [1:0] LOGIC_MVN = 2'b11;

    // KERNEL class
    localparam logic [1:0] KERN_ADD  = 2'b00;
    localparam logic [1:0] KERN_MUL  = 2'b01;
    localparam logic [1:0] KERN_SUB  = 2'b10;
    localparam logic [1:0] KERN_LD   = 2'b11;

    // SHIFT class
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // CPSR flag bit positions
    localparam int CPSR_N = 3;
    localparam int CPSR_Z = 2;
    localparam int CPSR_C = 1;
    localparam int CPSR_V = 0;

endpackage

// File: rtl/kernel_operand_sel.sv
// Effective operand B mux. For KERNEL-class operations with a valid row
// selected, OPB is an element index into that cache row (out-of-range index
// yields 0); in every other case OPB passes straight through.
module kernel_operand_sel
    import alu_pkg::*;
#(
    parameter int BUS = 4
) (
    input  logic [1:0]        funtype_i,
    input  logic [1:0]        kernelsel_i,
    input  logic [BUS-1:0]    opb_i,
    input  logic [KWIDTH-1:0] cache_i [0:KROWS-1],
    output logic [BUS-1:0]    eb_o
);

    localparam int NELEM = KWIDTH / BUS;

    logic [KWIDTH-1:0] row;
    logic [BUS-1:0]    elem [0:NELEM-1];

    // Pick the selected cache row; the "no kernel" code gives an all-zero row
    always_comb begin
        row = '0;
        case (kernelsel_i)
            2'd0:    row = cache_i[0];
            2'd1:    row = cache_i[1];
            2'd2:    row = cache_i[2];
            default: row = '0;
        endcase
    end

    // Split the row into BUS-wide elements, element 0 in the low bits
    for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
        assign elem[gi] = row[gi*BUS +: BUS];
    end

    // Index the row by OPB; comparing against each element index avoids an
    // out-of-range array access when OPB can exceed the element count
    always_comb begin
        eb_o = opb_i;
        if (funtype_i == KERNEL && kernelsel_i < 2'(KROWS)) begin
            eb_o = '0;
            for (int i = 0; i < NELEM; i++) begin
                if (opb_i == BUS'(i)) begin
                    eb_o = elem[i];
                end
            end
        end
    end

endmodule

// File: rtl/kernel_alu.sv
// Registered integer ALU for the execute stage: arithmetic, logic, kernel
// (cache operand) and shift operations with NZCV flags, one cycle latency.
// Build option: define ALU_MUL_EN to include the multiplier; without it the
// MUL codes return result 0 with only Z set.
module kernel_alu
    import alu_pkg::*;
#(
    parameter int BUS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BUS-1:0]    OPA,
    input  logic [BUS-1:0]    OPB,
    input  logic [1:0]        kernelsel,
    input  logic [KWIDTH-1:0] cache [0:KROWS-1],
    input  logic [1:0]        FUNTYPE,
    input  logic [1:0]        FUNCODE,
    output logic [BUS-1:0]    result,
    output logic [3:0]        CPSR,
    output logic [BUS-1:0]    operandB
);

    logic [BUS-1:0] eb;
    logic [BUS:0]   sum;
    logic [BUS-1:0] diff;
    logic           sub_c;
    logic           sub_v;
    logic [31:0]    amt;
    logic [BUS:0]   lsl_ext;
    logic [BUS:0]   rsh_ext;
    logic [BUS-1:0] asr_res;
    logic [BUS-1:0] ror_res;
    logic           shift_c;
    logic [BUS-1:0] mul_res;
    logic           mul_c;

    logic [BUS-1:0] result_d, result_q;
    logic [3:0]     cpsr_d, cpsr_q;
    logic [BUS-1:0] operandb_d, operandb_q;

    logic [BUS-1:0] res;
    logic           c_flag;
    logic           v_flag;

    kernel_operand_sel #(.BUS(BUS)) u_sel (
        .funtype_i   (FUNTYPE),
        .kernelsel_i (kernelsel),
        .opb_i       (OPB),
        .cache_i     (cache),
        .eb_o        (eb)
    );

    // Shared datapath pieces reused by several operation classes
    assign sum   = {1'b0, OPA} + {1'b0, eb};
    assign diff  = OPA - eb;
    assign sub_c = (OPA >= eb);
    assign sub_v = (OPA[BUS-1] != eb[BUS-1]) && (diff[BUS-1] != OPA[BUS-1]);

    // Shifts: the extra bit of each widened vector catches the last bit shifted out
    assign amt     = 32'(eb) % BUS;
    assign lsl_ext = {1'b0, OPA} << amt;
    assign rsh_ext = {OPA, 1'b0} >> amt;
    assign asr_res = BUS'($signed(OPA) >>> amt);
    assign ror_res = (OPA >> amt) | (OPA << (BUS - amt));

`ifdef ALU_MUL_EN
    logic [2*BUS-1:0] prod;
    assign prod    = {{BUS{1'b0}}, OPA} * {{BUS{1'b0}}, eb};
    assign mul_res = prod[BUS-1:0];
    assign mul_c   = |prod[2*BUS-1:BUS];
`else
    assign mul_res = '0;
    assign mul_c   = 1'b0;
`endif

    // Select the result and C/V flags for the requested operation
    always_comb begin
        res     = '0;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        shift_c = 1'b0;
        case (funtype_e'(FUNTYPE))
            ARITH: begin
                case (FUNCODE)
                    ARITH_ADD: begin res = sum[BUS-1:0]; c_flag = sum[BUS]; end
                    ARITH_SUB: begin res = diff; c_flag = sub_c; v_flag = sub_v; end
                    ARITH_MUL: begin res = mul_res; c_flag = mul_c; end
                    default:   res = eb;
                endcase
            end
            LOGIC: begin
                case (FUNCODE)
                    LOGIC_AND: res = OPA & eb;
                    LOGIC_ORR: res = OPA | eb;
                    LOGIC_EOR: res = OPA ^ eb;
                    default:   res = ~eb;
                endcase
            end
            KERNEL: begin
                case (FUNCODE)
                    KERN_ADD: begin res = sum[BUS-1:0]; c_flag = sum[BUS]; end
                    KERN_MUL: begin res = mul_res; c_flag = mul_c; end
                    KERN_SUB: begin res = diff; c_flag = sub_c; v_flag = sub_v; end
                    default:  res = eb;
                endcase
            end
            default: begin
                // amount 0 leaves both extension bits at 0, so C stays clear
                case (FUNCODE)
                    SHIFT_LSL: begin res = lsl_ext[BUS-1:0]; shift_c = lsl_ext[BUS]; end
                    SHIFT_LSR: begin res = rsh_ext[BUS:1];   shift_c = rsh_ext[0]; end
                    SHIFT_ASR: begin res = asr_res;          shift_c = rsh_ext[0]; end
                    default:   begin res = ror_res;          shift_c = rsh_ext[0]; end
                endcase
                c_flag = shift_c;
            end
        endcase
    end

    // Assemble the next register values
    always_comb begin
        result_d       = res;
        operandb_d     = eb;
        cpsr_d         = '0;
        cpsr_d[CPSR_N] = res[BUS-1];
        cpsr_d[CPSR_Z] = (res == '0);
        cpsr_d[CPSR_C] = c_flag;
        cpsr_d[CPSR_V] = v_flag;
    end

    // Output register stage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= '0;
            cpsr_q     <= '0;
            operandb_q <= '0;
        end else begin
            result_q   <= result_d;
            cpsr_q     <= cpsr_d;
            operandb_q <= operandb_d;
        end
    end

    assign result   = result_q;
    assign CPSR     = cpsr_q;
    assign operandB = operandb_q;

endmodule

// File: tb/tb_kernel_alu.sv
// Directed bench for kernel_alu (BUS=4): each step drives one operation,
// pushes its expected outputs to a scoreboard, and compares after the edge.
module tb_kernel_alu;

    localparam int BUS = 4;

    logic           clk;
    logic           rst_n;
    logic [BUS-1:0] OPA;
    logic [BUS-1:0] OPB;
    logic [1:0]     kernelsel;
    logic [23:0]    cache [0:2];
    logic [1:0]     FUNTYPE;
    logic [1:0]     FUNCODE;
    logic [BUS-1:0] result;
    logic [3:0]     CPSR;
    logic [BUS-1:0] operandB;

    typedef struct {
        string          tag;
        logic [BUS-1:0] res;
        logic [3:0]     cpsr;
        logic [BUS-1:0] opb;
    } exp_t;

    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    kernel_alu #(.BUS(BUS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .OPA       (OPA),
        .OPB       (OPB),
        .kernelsel (kernelsel),
        .cache     (cache),
        .FUNTYPE   (FUNTYPE),
        .FUNCODE   (FUNCODE),
        .result    (result),
        .CPSR      (CPSR),
        .operandB  (operandB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string tag, input string field,
                          input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, field, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare all three outputs against it
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check4(e.tag, "result", result, e.res);
            check4(e.tag, "CPSR", CPSR, e.cpsr);
            check4(e.tag, "operandB", operandB, e.opb);
            $display("step %-10s A=%b B=%b ft=%b fc=%b ks=%0d -> result=%b CPSR=%b operandB=%b",
                     e.tag, OPA, OPB, FUNTYPE, FUNCODE, kernelsel, result, CPSR, operandB);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] ft, input logic [1:0] fc,
                        input logic [1:0] ks, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic [3:0] ec, input logic [3:0] eo);
        exp_t e;
        FUNTYPE   = ft;
        FUNCODE   = fc;
        kernelsel = ks;
        OPA       = a;
        OPB       = b;
        e.tag  = tag;
        e.res  = er;
        e.cpsr = ec;
        e.opb  = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        cache[0] = 24'h000000;
        cache[1] = 24'h654321;
        cache[2] = 24'hFEDCBA;

        // Reset held two cycles with a nonzero operation on the inputs
        rst_n = 1'b0;
        step("rst0", 2'b00, 2'b00, 2'd3, 4'h7, 4'h7, 4'h0, 4'b0000, 4'h0);
        step("rst1", 2'b00, 2'b00, 2'd3, 4'h7, 4'h7, 4'h0, 4'b0000, 4'h0);
        rst_n = 1'b1;

        // ADD
        step("add2+1",  2'b00, 2'b00, 2'd3, 4'h2, 4'h1, 4'b0011, 4'b0000, 4'h1);
        step("add7+7",  2'b00, 2'b00, 2'd3, 4'h7, 4'h7, 4'b1110, 4'b1000, 4'h7);
        step("addF+1",  2'b00, 2'b00, 2'd3, 4'hF, 4'h1, 4'b0000, 4'b0110, 4'h1);
        // SUB
        step("sub3-5",  2'b00, 2'b01, 2'd3, 4'h3, 4'h5, 4'b1110, 4'b1000, 4'h5);
        step("sub8-1",  2'b00, 2'b01, 2'd3, 4'h8, 4'h1, 4'b0111, 4'b0011, 4'h1);
        step("sub5-5",  2'b00, 2'b01, 2'd3, 4'h5, 4'h5, 4'b0000, 4'b0110, 4'h5);
        // MOV and logic
        step("mov",     2'b00, 2'b11, 2'd3, 4'h3, 4'h9, 4'b1001, 4'b1000, 4'h9);
        step("and",     2'b01, 2'b00, 2'd3, 4'hC, 4'hA, 4'b1000, 4'b1000, 4'hA);
        step("orr",     2'b01, 2'b01, 2'd3, 4'h4, 4'h2, 4'b0110, 4'b0000, 4'h2);
        step("eor",     2'b01, 2'b10, 2'd3, 4'h5, 4'h5, 4'b0000, 4'b0100, 4'h5);
        step("mvn",     2'b01, 2'b11, 2'd3, 4'h5, 4'h0, 4'b1111, 4'b1000, 4'h0);
        // Kernel operand selection
        step("kadd_r1", 2'b10, 2'b00, 2'd1, 4'h1, 4'h2, 4'b0100, 4'b0000, 4'h3);
        step("kadd_oor",2'b10, 2'b00, 2'd1, 4'h1, 4'h7, 4'b0001, 4'b0000, 4'h0);
        step("kadd_ks3",2'b10, 2'b00, 2'd3, 4'h1, 4'h2, 4'b0011, 4'b0000, 4'h2);
        step("kadd_e5", 2'b10, 2'b00, 2'd1, 4'h1, 4'h5, 4'b0111, 4'b0000, 4'h6);
        step("ksub",    2'b10, 2'b10, 2'd1, 4'h1, 4'h1, 4'b1111, 4'b1000, 4'h2);
        step("kld_r2",  2'b10, 2'b11, 2'd2, 4'h0, 4'h0, 4'b1010, 4'b1000, 4'hA);
        // Shifts
        step("lsl",     2'b11, 2'b00, 2'd3, 4'h9, 4'h1, 4'b0010, 4'b0010, 4'h1);
        step("lsr",     2'b11, 2'b01, 2'd3, 4'h9, 4'h1, 4'b0100, 4'b0010, 4'h1);
        step("asr",     2'b11, 2'b10, 2'd3, 4'h8, 4'h2, 4'b1110, 4'b1000, 4'h2);
        step("ror",     2'b11, 2'b11, 2'd3, 4'h1, 4'h1, 4'b1000, 4'b1010, 4'h1);
        step("lsl_by4", 2'b11, 2'b00, 2'd3, 4'h9, 4'h4, 4'b1001, 4'b1000, 4'h4);
        // Multiply
`ifdef ALU_MUL_EN
        step("mul3*6",  2'b00, 2'b10, 2'd3, 4'h3, 4'h6, 4'b0010, 4'b0010, 4'h6);
        step("kmul",    2'b10, 2'b01, 2'd1, 4'h3, 4'h1, 4'b0110, 4'b0000, 4'h2);
`else
        step("mul3*6",  2'b00, 2'b10, 2'd3, 4'h3, 4'h6, 4'b0000, 4'b0100, 4'h6);
        step("kmul",    2'b10, 2'b01, 2'd1, 4'h3, 4'h1, 4'b0000, 4'b0100, 4'h2);
`endif
        // Reset wins over a live operation
        rst_n = 1'b0;
        step("rst_mid", 2'b00, 2'b00, 2'd3, 4'hF, 4'h1, 4'h0, 4'b0000, 4'h0);
        rst_n = 1'b1;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
